// File: rtl/base_pkg.sv
// Shared helpers for the little/big-endian bus adapters.
// Byte-reversal index mapping, usable in constant (elaboration-time) expressions.
package base_pkg;

    localparam int unsigned BASE_BYTE_W = 8;

    // Source bit index for output bit bit_idx when a bus of nbytes bytes is byte-reversed.
    function automatic int unsigned base_byterev(input int unsigned bit_idx,
                                                 input int unsigned nbytes);
        int unsigned b;
        int unsigned j;
        b = bit_idx / BASE_BYTE_W;
        j = bit_idx % BASE_BYTE_W;
        return BASE_BYTE_W * (nbytes - 1 - b) + j;
    endfunction

endpackage

// File: rtl/base_skid_reg.sv
// Generic two-entry valid/ready skid buffer: main register drives the output, skid register
// absorbs the beat accepted while the output stalls. Ready is registered (no o_r -> i_r path).
module base_skid_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,      // synchronous, active-low
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             m_v_q, m_v_d;
    logic             s_v_q, s_v_d;
    logic             rdy_q;
    logic [Width-1:0] m_data_q, m_data_d;
    logic [Width-1:0] s_data_q, s_data_d;
    logic             accept;
    logic             take;

    assign accept = in_valid_i & rdy_q;
    assign take   = m_v_q & out_ready_i;

    always_comb begin
        m_v_d    = m_v_q;
        s_v_d    = s_v_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (take) begin
            if (s_v_q) begin
                m_data_d = s_data_q;
                s_v_d    = 1'b0;
            end else begin
                m_v_d = 1'b0;
            end
        end
        // accept implies the skid slot is empty, so a beat never overwrites s_data_q
        if (accept) begin
            if (!m_v_q || take) begin
                m_v_d    = 1'b1;
                m_data_d = in_data_i;
            end else begin
                s_v_d    = 1'b1;
                s_data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_v_q    <= 1'b0;
            s_v_q    <= 1'b0;
            rdy_q    <= 1'b0;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            m_v_q    <= m_v_d;
            s_v_q    <= s_v_d;
            rdy_q    <= ~s_v_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = m_v_q;
    assign out_data_o  = m_data_q;

endmodule

// File: rtl/base_bitunswap_pipe.sv
// Little-endian [width-1:0] input to big-endian [0:width-1] output, with optional per-beat
// byte reversal, a registered skid stage and a free-running accepted-beat counter.
module base_bitunswap_pipe
    import base_pkg::*;
#(
    parameter int unsigned width = 64,
    parameter int unsigned cnt_w = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    input  logic             i_bswap,
    output logic             o_v,
    input  logic             o_r,
    output logic [0:width-1] o_d,
    output logic [cnt_w-1:0] o_beats
);

    localparam int unsigned NumBytes = width / BASE_BYTE_W;

    if ((width % BASE_BYTE_W) != 0 || width == 0) begin : g_bad_width
        $error("base_bitunswap_pipe: width must be a non-zero multiple of 8");
    end

    logic [width-1:0] mapped;
    logic [width-1:0] m_data;
    logic [cnt_w-1:0] beats_q, beats_d;
    logic             accept;

    // Same numeric index on both sides: the [0:n] declaration of o_d does the bit reversal.
    for (genvar k = 0; k < width; k++) begin : g_map
        localparam int unsigned Src = base_byterev(k, NumBytes);
        assign mapped[k] = i_bswap ? i_d[Src] : i_d[k];
        assign o_d[k]    = m_data[k];
    end

    base_skid_reg #(
        .Width (width)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .in_valid_i  (i_v),
        .in_ready_o  (i_r),
        .in_data_i   (mapped),
        .out_valid_o (o_v),
        .out_ready_i (o_r),
        .out_data_o  (m_data)
    );

    assign accept = i_v & i_r;

    always_comb begin
        beats_d = beats_q;
        if (accept) begin
            beats_d = beats_q + cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign o_beats = beats_q;

endmodule
